// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: shared widths, ALU encodings and the ID/EX micro-op layout.
package id_ex_operand_stage_pkg;

    localparam int DEF_XLEN   = 64;
    localparam int DEF_REG_AW = 5;

    localparam logic [2:0] ALU_SEL_ADD  = 3'b000;
    localparam logic [2:0] ALU_SEL_ANDN = 3'b001;
    localparam logic [2:0] ALU_SEL_AND  = 3'b010;
    localparam logic [2:0] ALU_SEL_OR   = 3'b011;
    localparam logic [2:0] ALU_SEL_XOR  = 3'b100;
    localparam logic [2:0] ALU_SEL_SRA  = 3'b101;
    localparam logic [2:0] ALU_SEL_SLL  = 3'b110;
    localparam logic [2:0] ALU_SEL_SRL  = 3'b111;

    typedef struct packed {
        logic [DEF_XLEN-1:0]   pc;
        logic [DEF_XLEN-1:0]   rs1_data;
        logic [DEF_XLEN-1:0]   rs2_data;
        logic [DEF_XLEN-1:0]   imm;
        logic [DEF_REG_AW-1:0] rs1_addr;
        logic [DEF_REG_AW-1:0] rs2_addr;
        logic [DEF_REG_AW-1:0] rd;
        logic [2:0]            alu_sel;
        logic                  sub;
        logic                  use_pc;
        logic                  use_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } id_ex_uop_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// id_ex_operand_stage_fwd_mux: priority operand forwarding, EX/MEM over MEM/WB, x0 never forwarded.
module id_ex_operand_stage_fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   data,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   fwd
);

    logic ex_hit;
    logic wb_hit;

    // A load in EX/MEM has no data yet; the load-use bubble covers that case.
    assign ex_hit = exmem_reg_write && exmem_rd != '0 && exmem_rd == addr && !exmem_mem_read;
    assign wb_hit = memwb_reg_write && memwb_rd != '0 && memwb_rd == addr;
    assign fwd    = ex_hit ? exmem_result : wb_hit ? memwb_result : data;

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with RAW forwarding and load-use bubble insertion
// feeding the 64-bit ALU and the memory-stage control fields.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [2:0]        in_alu_sel,
    input  logic              in_sub,
    input  logic              in_use_pc,
    input  logic              in_use_imm,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              flush,
    input  logic              out_ready,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              out_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_sel,
    output logic              alu_sub,
    output logic [XLEN-1:0]   out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              load_use_stall
);

    id_ex_uop_t      q;
    id_ex_uop_t      in_uop;
    logic            valid;
    logic            advance;
    logic            hazard;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign in_uop = '{pc: in_pc, rs1_data: in_rs1_data, rs2_data: in_rs2_data, imm: in_imm,
                      rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr, rd: in_rd_addr,
                      alu_sel: in_alu_sel, sub: in_sub, use_pc: in_use_pc, use_imm: in_use_imm,
                      reg_write: in_reg_write, mem_read: in_mem_read, mem_write: in_mem_write};

    assign advance = !valid || out_ready;
    assign hazard  = valid && q.mem_read && q.rd != '0 && in_valid &&
                     ((!in_use_pc && in_rs1_addr == q.rd) ||
                      (!in_use_imm && in_rs2_addr == q.rd) ||
                      (in_mem_write && in_rs2_addr == q.rd));

    assign load_use_stall = hazard;
    assign in_ready       = advance && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance && hazard) begin
            valid <= 1'b0;
        end else if (advance) begin
            q     <= in_uop;
            valid <= in_valid;
        end else begin
            // Latch forwarded operands so producers may retire while we stall.
            q.rs1_data <= fwd_rs1;
            q.rs2_data <= fwd_rs2;
        end
    end

    id_ex_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) fwd_mux_rs1 (
        .addr(q.rs1_addr), .data(q.rs1_data),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .fwd(fwd_rs1)
    );

    id_ex_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) fwd_mux_rs2 (
        .addr(q.rs2_addr), .data(q.rs2_data),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .fwd(fwd_rs2)
    );

    assign out_valid      = valid;
    assign alu_a          = q.use_pc ? q.pc : fwd_rs1;
    assign alu_b          = q.use_imm ? q.imm : fwd_rs2;
    assign out_store_data = fwd_rs2;
    assign alu_sel        = q.alu_sel;
    assign alu_sub        = q.sub;
    assign out_rd         = valid ? q.rd : '0;
    assign out_reg_write  = valid && q.reg_write;
    assign out_mem_read   = valid && q.mem_read;
    assign out_mem_write  = valid && q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vectors for capture, forwarding, load-use, hold and flush.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_alu_sel;
    logic        in_sub;
    logic        in_use_pc;
    logic        in_use_imm;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        flush;
    logic        out_ready;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic [63:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [63:0] memwb_result;
    logic        out_valid;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_sel;
    logic        alu_sub;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        load_use_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_sel(in_alu_sel), .in_sub(in_sub), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .flush(flush), .out_ready(out_ready),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_sub(alu_sub),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .load_use_stall(load_use_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [4:0] rs1a, input logic [63:0] rs1d, input logic [4:0] rs2a,
                      input logic [63:0] rs2d, input logic [4:0] rd, input logic [2:0] sel,
                      input logic sub, input logic rw, input logic mr, input logic mw);
        in_valid     = 1'b1;
        in_rs1_addr  = rs1a;
        in_rs1_data  = rs1d;
        in_rs2_addr  = rs2a;
        in_rs2_data  = rs2d;
        in_rd_addr   = rd;
        in_alu_sel   = sel;
        in_sub       = sub;
        in_reg_write = rw;
        in_mem_read  = mr;
        in_mem_write = mw;
        in_use_pc    = 1'b0;
        in_use_imm   = 1'b0;
        in_pc        = 64'h0;
        in_imm       = 64'h0;
    endtask

    task automatic clear_fwd();
        exmem_rd        = '0;
        exmem_reg_write = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_result    = '0;
        memwb_rd        = '0;
        memwb_reg_write = 1'b0;
        memwb_result    = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        op(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        in_valid = 1'b0;
        clear_fwd();
        #2;
        check("reset_valid", 64'(out_valid), 0);
        check("reset_stall", 64'(load_use_stall), 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_store", out_store_data, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 1);

        // plain add
        op(1, 64'h5, 2, 64'h3, 10, 3'b000, 0, 1, 0, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("add_valid", 64'(out_valid), 1);
        check("add_alu_a", alu_a, 64'h5);
        check("add_alu_b", alu_b, 64'h3);
        check("add_rd", 64'(out_rd), 10);
        check("add_reg_write", 64'(out_reg_write), 1);

        // pc / imm selects, subtract and select passthrough
        op(1, 64'h5, 2, 64'h3, 4, 3'b101, 1, 1, 0, 0);
        in_use_pc  = 1'b1;
        in_use_imm = 1'b1;
        in_pc      = 64'h1000;
        in_imm     = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        in_valid = 1'b0;
        #1;
        check("sel_alu_a_pc", alu_a, 64'h1000);
        check("sel_alu_b_imm", alu_b, 64'hFFFF_FFFF_FFFF_FFFC);
        check("sel_store_rs2", out_store_data, 64'h3);
        check("sel_alu_sub", 64'(alu_sub), 1);
        check("sel_alu_sel", 64'(alu_sel), 5);

        // forwarding priority on held op
        op(7, 64'h11, 8, 64'h22, 9, 3'b000, 0, 1, 0, 0);
        tick();
        in_valid        = 1'b0;
        exmem_rd        = 7;
        exmem_reg_write = 1'b1;
        exmem_result    = 64'hAA;
        memwb_rd        = 7;
        memwb_reg_write = 1'b1;
        memwb_result    = 64'hBB;
        #1;
        check("fwd_exmem_prio", alu_a, 64'hAA);
        exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb", alu_a, 64'hBB);
        exmem_reg_write = 1'b1;
        exmem_mem_read  = 1'b1;
        #1;
        check("fwd_exmem_load_skip", alu_a, 64'hBB);
        exmem_mem_read = 1'b0;
        memwb_rd       = 8;
        #1;
        check("fwd_split_a", alu_a, 64'hAA);
        check("fwd_split_b", alu_b, 64'hBB);
        check("fwd_split_store", out_store_data, 64'hBB);
        clear_fwd();

        // x0 never forwarded
        op(0, 64'h33, 0, 64'h44, 9, 3'b000, 0, 1, 0, 0);
        tick();
        in_valid        = 1'b0;
        exmem_reg_write = 1'b1;
        exmem_result    = 64'hAA;
        memwb_reg_write = 1'b1;
        memwb_result    = 64'hBB;
        #1;
        check("fwd_x0_a", alu_a, 64'h33);
        check("fwd_x0_b", alu_b, 64'h44);
        clear_fwd();

        // load-use: LD x5 then ADD x6,x5,x1
        op(1, 64'h100, 0, 0, 5, 3'b000, 0, 1, 1, 0);
        in_use_imm = 1'b1;
        in_imm     = 64'h8;
        tick();
        op(5, 64'hDEAD, 1, 64'h7, 6, 3'b000, 0, 1, 0, 0);
        #1;
        check("lu_stall", 64'(load_use_stall), 1);
        check("lu_in_ready", 64'(in_ready), 0);
        check("lu_ld_mem_read", 64'(out_mem_read), 1);
        tick();
        check("lu_bubble_valid", 64'(out_valid), 0);
        check("lu_bubble_mem_read", 64'(out_mem_read), 0);
        check("lu_bubble_stall", 64'(load_use_stall), 0);
        check("lu_bubble_in_ready", 64'(in_ready), 1);
        tick();
        in_valid        = 1'b0;
        memwb_rd        = 5;
        memwb_reg_write = 1'b1;
        memwb_result    = 64'h1234;
        #1;
        check("lu_add_valid", 64'(out_valid), 1);
        check("lu_add_rd", 64'(out_rd), 6);
        check("lu_add_alu_a", alu_a, 64'h1234);
        check("lu_add_alu_b", alu_b, 64'h7);
        clear_fwd();

        // load into x0 never stalls; store data dependency does
        op(1, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0);
        tick();
        op(0, 0, 0, 0, 3, 3'b000, 0, 1, 0, 0);
        #1;
        check("lu_x0_no_stall", 64'(load_use_stall), 0);
        op(1, 0, 0, 0, 5, 3'b000, 0, 1, 1, 0);
        tick();
        op(2, 0, 5, 0, 0, 3'b000, 0, 0, 0, 1);
        in_use_imm = 1'b1;
        #1;
        check("lu_store_stall", 64'(load_use_stall), 1);
        in_valid = 1'b0;
        tick();

        // hold with drain
        op(3, 64'h1, 4, 64'h44, 11, 3'b000, 0, 1, 0, 0);
        tick();
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        memwb_rd        = 4;
        memwb_reg_write = 1'b1;
        memwb_result    = 64'h99;
        #1;
        check("hold_c1_alu_b", alu_b, 64'h99);
        check("hold_in_ready", 64'(in_ready), 0);
        tick();
        clear_fwd();
        #1;
        check("hold_c2_alu_b", alu_b, 64'h99);
        tick();
        check("hold_c3_alu_b", alu_b, 64'h99);
        check("hold_c3_valid", 64'(out_valid), 1);
        check("hold_c3_alu_a", alu_a, 64'h1);
        out_ready = 1'b1;
        tick();
        check("hold_release_valid", 64'(out_valid), 0);

        // flush kills a held op while downstream is stalled, drops the incoming op
        op(1, 64'h1, 2, 64'h2, 12, 3'b000, 0, 1, 0, 0);
        tick();
        out_ready = 1'b0;
        op(1, 64'h1, 2, 64'h2, 13, 3'b000, 0, 1, 0, 0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_valid", 64'(out_valid), 0);
        check("flush_reg_write", 64'(out_reg_write), 0);
        check("flush_rd", 64'(out_rd), 0);
        out_ready = 1'b1;
        tick();
        check("flush_no_incoming", 64'(out_valid), 0);

        // asynchronous reset mid-operation
        op(1, 64'h55, 2, 64'h66, 14, 3'b000, 0, 1, 1, 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("mid_pre_valid", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_mem_read", 64'(out_mem_read), 0);
        check("mid_rst_alu_a", alu_a, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 1);
        check("mid_rst_idle", 64'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
